fscale2: RTL

- Pipelined single-precision scale-by-power-of-two unit: result = op × 2^k, with k a signed runtime operand.
- Generalises the fixed halving unit: arbitrary signed scale, correct subnormal inputs and outputs, round-to-nearest-even, overflow to infinity, NaN quieting, IEEE status flags, optional flush-to-zero mode.
- Full valid/ready handshake on both sides.
- Sits in the FPU alongside the other single-op units; feeds the writeback arbiter.

---
 rtl/fscale2.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fscale2.sv
// fscale2: two-stage pipelined binary32 scale-by-power-of-two (result = op * 2^k).
// Round-to-nearest-even, gradual or flushed underflow, overflow to infinity,
// NaN quieting, and {overflow, underflow, inexact} status flags.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  input handshake for op/k
//   op, k           binary32 operand, signed K_WIDTH-bit exponent adjustment
//   out_valid/ready output handshake for result/flags
//   result, flags   scaled value and {overflow, underflow, inexact}
module fscale2 #(
  parameter int unsigned K_WIDTH = 9,
  parameter bit          FTZ     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        op,
  input  logic [K_WIDTH-1:0] k,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        result,
  output logic [2:0]         flags
);

  // Biased exponent width: wide enough that exp + k never wraps.
  localparam int unsigned EW = K_WIDTH + 2;
  localparam logic signed [EW-1:0] E_INF = EW'(255);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  logic          s1_valid_q, s1_valid_d;
  logic          s1_special_q, s1_special_d;
  logic [31:0]   s1_pass_q, s1_pass_d;
  logic          s1_sign_q, s1_sign_d;
  logic [23:0]   s1_m_q, s1_m_d;
  logic [EW-1:0] s1_e_q, s1_e_d;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   result_q, result_d;
  logic [2:0]    flags_q, flags_d;

  logic s2_advance_c;
  logic s1_advance_c;
  logic in_fire_c;

  // Handshake: stage 2 moves when empty or drained; stage 1 follows it.
  assign s2_advance_c = !out_valid_q || out_ready;
  assign s1_advance_c = s1_valid_q && s2_advance_c;
  assign in_ready     = !s1_valid_q || s2_advance_c;
  assign in_fire_c    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Stage 1: classify, normalise subnormals to a hidden-bit mantissa, add k.
  always_comb begin
    logic [7:0]    exp_in;
    logic [22:0]   frac_in;
    logic [4:0]    lz;
    logic [EW-1:0] e_ext;
    logic [EW-1:0] k_ext;

    s1_valid_d   = s1_valid_q;
    s1_special_d = s1_special_q;
    s1_pass_d    = s1_pass_q;
    s1_sign_d    = s1_sign_q;
    s1_m_d       = s1_m_q;
    s1_e_d       = s1_e_q;

    exp_in  = op[30:23];
    frac_in = op[22:0];

    lz = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (frac_in[i]) lz = 5'(22 - i);
    end

    k_ext = {{2{k[K_WIDTH-1]}}, k};
    e_ext = (exp_in != 8'd0) ? EW'(exp_in) : (EW'(0) - EW'(lz));

    if (in_fire_c) begin
      s1_valid_d   = 1'b1;
      s1_sign_d    = op[31];
      s1_special_d = (exp_in == 8'hFF) || ((exp_in == 8'd0) && (frac_in == 23'd0));
      // NaNs are quieted; Inf and zero pass through untouched.
      s1_pass_d    = ((exp_in == 8'hFF) && (frac_in != 23'd0))
                     ? {op[31], 8'hFF, 1'b1, frac_in[21:0]} : op;
      s1_m_d       = (exp_in != 8'd0) ? {1'b1, frac_in}
                                      : ({1'b0, frac_in} << (lz + 5'd1));
      s1_e_d       = e_ext + k_ext;
    end else if (s1_advance_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: overflow, exact repack, or denormalise with round-to-nearest-even.
  always_comb begin
    logic [EW-1:0] sh_amt;
    logic [47:0]   shifted;
    logic [23:0]   mant;
    logic          guard;
    logic          sticky;
    logic          round_up;
    logic [23:0]   rounded;

    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    sh_amt   = EW'(1) - s1_e_q;
    shifted  = {s1_m_q, 24'd0} >> sh_amt[4:0];
    if (sh_amt >= EW'(26)) begin
      mant   = 24'd0;
      guard  = 1'b0;
      sticky = 1'b1;
    end else begin
      mant   = shifted[47:24];
      guard  = shifted[23];
      sticky = |shifted[22:0];
    end
    round_up = guard && (sticky || mant[0]);
    rounded  = mant + 24'(round_up);

    if (s2_advance_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_special_q) begin
          result_d = s1_pass_q;
          flags_d  = 3'b000;
        end else if ($signed(s1_e_q) >= E_INF) begin
          result_d = {s1_sign_q, 8'hFF, 23'd0};
          flags_d  = 3'b101;
        end else if ($signed(s1_e_q) >= E_ONE) begin
          result_d = {s1_sign_q, s1_e_q[7:0], s1_m_q[22:0]};
          flags_d  = 3'b000;
        end else if (FTZ) begin
          result_d = {s1_sign_q, 31'd0};
          flags_d  = 3'b011;
        end else begin
          // A carry into bit 23 lands in the exponent LSB, giving min normal.
          result_d = {s1_sign_q, 7'd0, rounded};
          flags_d  = {1'b0, guard || sticky, guard || sticky};
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_special_q <= 1'b0;
      s1_pass_q    <= 32'd0;
      s1_sign_q    <= 1'b0;
      s1_m_q       <= 24'd0;
      s1_e_q       <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= 32'd0;
      flags_q      <= 3'b000;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_special_q <= s1_special_d;
      s1_pass_q    <= s1_pass_d;
      s1_sign_q    <= s1_sign_d;
      s1_m_q       <= s1_m_d;
      s1_e_q       <= s1_e_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

endmodule
